// File: rtl/bulk_loopback_fifo_pkg.sv
// Shared USB definitions for the bulk loopback datapath.
package bulk_loopback_fifo_pkg;

  // High-speed bulk max packet size in bytes.
  localparam int unsigned HS_MAX_PKT = 512;

  // Output-stage FSM encoding.
  localparam logic [1:0] StEmpty = 2'd0;  // output register holds no word
  localparam logic [1:0] StFetch = 2'd1;  // RAM read in flight
  localparam logic [1:0] StValid = 2'd2;  // output register presented on m_t*

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on contents.
module sdp_ram #(
  parameter int unsigned DW = 9,
  parameter int unsigned AW = 11
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [0:(2**AW)-1];

  // Write port.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; data is valid the cycle after rd_en.
  always_ff @(posedge clock) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/bulk_loopback_fifo.sv
// First-word-fall-through loopback FIFO between a USB bulk OUT and IN endpoint.
// Storage is a registered-read RAM followed by a one-word output register; level_o
// counts both. Both handshakes are gated by cycle_i.
module bulk_loopback_fifo
  import bulk_loopback_fifo_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ABITS       = 11,
  parameter int unsigned IN_THRESH   = 5,
  parameter int unsigned OUT_SPACE   = HS_MAX_PKT,
  parameter int unsigned PACKET_MODE = 1
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             configured_i,
  input  logic             cycle_i,
  input  logic             s_tvalid_i,
  output logic             s_tready_o,
  input  logic             s_tlast_i,
  input  logic [WIDTH-1:0] s_tdata_i,
  output logic             m_tvalid_o,
  input  logic             m_tready_i,
  output logic             m_tlast_o,
  output logic [WIDTH-1:0] m_tdata_o,
  output logic             blk_in_ready_o,
  output logic             blk_out_ready_o,
  output logic [ABITS:0]   level_o,
  output logic [ABITS:0]   pkt_cnt_o,
  output logic             overflow_o
);

  localparam logic [ABITS:0]   DepthW  = {1'b1, {ABITS{1'b0}}};
  localparam logic [ABITS:0]   InThrW  = (ABITS+1)'(IN_THRESH);
  localparam logic [ABITS:0]   OutSpcW = (ABITS+1)'(OUT_SPACE);
  localparam logic [ABITS:0]   CntOne  = (ABITS+1)'(1);
  localparam logic [ABITS-1:0] PtrOne  = ABITS'(1);

  logic [ABITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ABITS:0]   ram_cnt_q, ram_cnt_d;
  logic [ABITS:0]   level_q, level_d;
  logic [ABITS:0]   pkt_q, pkt_d;
  logic [1:0]       state_q, state_d;
  logic [WIDTH:0]   out_q, out_d;
  logic [WIDTH:0]   ram_rdata;
  logic             s_tready_q, s_tready_d;
  logic             blk_in_q, blk_in_d;
  logic             blk_out_q, blk_out_d;
  logic             ovf_q, ovf_d;
  logic             wr_fire, rd_fire, ram_rd;

  assign wr_fire = cycle_i && s_tvalid_i && s_tready_q && !flush_i;
  assign rd_fire = cycle_i && m_tready_i && (state_q == StValid) && !flush_i;

  // Output-stage FSM; ram_rd pops one word from RAM whenever FETCH is entered.
  always_comb begin
    state_d = state_q;
    ram_rd  = 1'b0;
    if (flush_i) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (ram_cnt_q != '0) begin
            state_d = StFetch;
            ram_rd  = 1'b1;
          end
        end
        StFetch: state_d = StValid;
        StValid: begin
          if (rd_fire) begin
            if (ram_cnt_q != '0) begin
              state_d = StFetch;
              ram_rd  = 1'b1;
            end else begin
              state_d = StEmpty;
            end
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // Pointers, occupancy and packet counters; flush discards any concurrent transfer.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ram_cnt_d = ram_cnt_q;
    level_d   = level_q;
    pkt_d     = pkt_q;
    if (flush_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      ram_cnt_d = '0;
      level_d   = '0;
      pkt_d     = '0;
    end else begin
      if (wr_fire) wr_ptr_d = wr_ptr_q + PtrOne;
      if (ram_rd)  rd_ptr_d = rd_ptr_q + PtrOne;
      case ({wr_fire, ram_rd})
        2'b10:   ram_cnt_d = ram_cnt_q + CntOne;
        2'b01:   ram_cnt_d = ram_cnt_q - CntOne;
        default: ram_cnt_d = ram_cnt_q;
      endcase
      case ({wr_fire, rd_fire})
        2'b10:   level_d = level_q + CntOne;
        2'b01:   level_d = level_q - CntOne;
        default: level_d = level_q;
      endcase
      case ({wr_fire && s_tlast_i, rd_fire && out_q[WIDTH]})
        2'b10:   pkt_d = pkt_q + CntOne;
        2'b01:   pkt_d = pkt_q - CntOne;
        default: pkt_d = pkt_q;
      endcase
    end
  end

  // Registered status flags and the output word.
  always_comb begin
    out_d      = out_q;
    s_tready_d = 1'b0;
    blk_in_d   = 1'b0;
    blk_out_d  = 1'b0;
    ovf_d      = 1'b0;
    if (!flush_i) begin
      if (state_q == StFetch) out_d = ram_rdata;
      // Look at next-cycle level so back-to-back writes never overrun.
      s_tready_d = level_d < DepthW;
      blk_in_d   = configured_i &&
                   ((level_q >= InThrW) || ((PACKET_MODE != 0) && (pkt_q != '0)));
      blk_out_d  = configured_i && ((DepthW - level_q) >= OutSpcW);
      ovf_d      = ovf_q || (s_tvalid_i && cycle_i && !s_tready_q);
    end else begin
      out_d = '0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      level_q    <= '0;
      pkt_q      <= '0;
      state_q    <= StEmpty;
      out_q      <= '0;
      s_tready_q <= 1'b0;
      blk_in_q   <= 1'b0;
      blk_out_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      level_q    <= level_d;
      pkt_q      <= pkt_d;
      state_q    <= state_d;
      out_q      <= out_d;
      s_tready_q <= s_tready_d;
      blk_in_q   <= blk_in_d;
      blk_out_q  <= blk_out_d;
      ovf_q      <= ovf_d;
    end
  end

  sdp_ram #(
    .DW(WIDTH + 1),
    .AW(ABITS)
  ) u_ram (
    .clock  (clock),
    .wr_en  (wr_fire),
    .wr_addr(wr_ptr_q),
    .wr_data({s_tlast_i, s_tdata_i}),
    .rd_en  (ram_rd),
    .rd_addr(rd_ptr_q),
    .rd_data(ram_rdata)
  );

  assign s_tready_o      = s_tready_q;
  assign m_tvalid_o      = (state_q == StValid);
  assign m_tlast_o       = out_q[WIDTH];
  assign m_tdata_o       = out_q[WIDTH-1:0];
  assign blk_in_ready_o  = blk_in_q;
  assign blk_out_ready_o = blk_out_q;
  assign level_o         = level_q;
  assign pkt_cnt_o       = pkt_q;
  assign overflow_o      = ovf_q;

endmodule

// File: tb/tb_bulk_loopback_fifo.sv
// Directed bench for bulk_loopback_fifo: a per-cycle vector table plus multi-cycle sequences.
module tb_bulk_loopback_fifo;

  localparam int DEPTH = 2048;

  logic       clock = 1'b0;
  logic       rst_n = 1'b1;
  logic       flush_i = 1'b0, configured_i = 1'b0, cycle_i = 1'b0;
  logic       s_tvalid_i = 1'b0, s_tlast_i = 1'b0, m_tready_i = 1'b0;
  logic [7:0] s_tdata_i = 8'h00;

  logic        s_tready_o, m_tvalid_o, m_tlast_o, blk_in_ready_o, blk_out_ready_o, overflow_o;
  logic [7:0]  m_tdata_o;
  logic [11:0] level_o, pkt_cnt_o;

  logic        p0_s_tready, p0_m_tvalid, p0_m_tlast, p0_blk_in, p0_blk_out, p0_ovf;
  logic [7:0]  p0_m_tdata;
  logic [11:0] p0_level, p0_pkt;

  always #5 clock = ~clock;

  bulk_loopback_fifo #(
    .WIDTH(8), .ABITS(11), .IN_THRESH(5), .OUT_SPACE(512), .PACKET_MODE(1)
  ) dut (
    .clock(clock), .rst_n(rst_n), .flush_i(flush_i), .configured_i(configured_i),
    .cycle_i(cycle_i), .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o),
    .s_tlast_i(s_tlast_i), .s_tdata_i(s_tdata_i), .m_tvalid_o(m_tvalid_o),
    .m_tready_i(m_tready_i), .m_tlast_o(m_tlast_o), .m_tdata_o(m_tdata_o),
    .blk_in_ready_o(blk_in_ready_o), .blk_out_ready_o(blk_out_ready_o),
    .level_o(level_o), .pkt_cnt_o(pkt_cnt_o), .overflow_o(overflow_o)
  );

  // Same stimulus, packet mode off.
  bulk_loopback_fifo #(
    .WIDTH(8), .ABITS(11), .IN_THRESH(5), .OUT_SPACE(512), .PACKET_MODE(0)
  ) dut_p0 (
    .clock(clock), .rst_n(rst_n), .flush_i(flush_i), .configured_i(configured_i),
    .cycle_i(cycle_i), .s_tvalid_i(s_tvalid_i), .s_tready_o(p0_s_tready),
    .s_tlast_i(s_tlast_i), .s_tdata_i(s_tdata_i), .m_tvalid_o(p0_m_tvalid),
    .m_tready_i(m_tready_i), .m_tlast_o(p0_m_tlast), .m_tdata_o(p0_m_tdata),
    .blk_in_ready_o(p0_blk_in), .blk_out_ready_o(p0_blk_out),
    .level_o(p0_level), .pkt_cnt_o(p0_pkt), .overflow_o(p0_ovf)
  );

  typedef struct {
    int flush, cfg, cyc, sv, sl, sd, mr;           // inputs for one clock
    int mv, md, ml, lvl, pkt, bin, bout, str;      // expected after that edge
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_flush();
    s_tvalid_i = 1'b0;
    m_tready_i = 1'b0;
    flush_i    = 1'b1;
    tick();
    flush_i    = 1'b0;
    tick();
  endtask

  task automatic write_byte(input logic [7:0] d, input logic last);
    s_tvalid_i = 1'b1;
    s_tdata_i  = d;
    s_tlast_i  = last;
    tick();
    s_tvalid_i = 1'b0;
    s_tlast_i  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, guard, sent, got, errs, both, lvl_m, pkt_m;
    bit wf, rf, rl;
    logic [8:0] exp_w;
    logic [8:0] sb [$];

    //                  fl cf cy sv sl sd     mr  mv md     ml lvl pkt bin bout str
    vecs[0]  = '{0, 1, 1, 1, 1, 'hA5, 0,  0, 0,     0, 1,  1,  0,  1,   1};
    vecs[1]  = '{0, 1, 1, 0, 0, 0,    0,  0, 0,     0, 1,  1,  1,  1,   1};
    vecs[2]  = '{0, 1, 1, 0, 0, 0,    0,  1, 'hA5,  1, 1,  1,  1,  1,   1};
    vecs[3]  = '{0, 1, 1, 0, 0, 0,    0,  1, 'hA5,  1, 1,  1,  1,  1,   1};
    vecs[4]  = '{0, 1, 0, 1, 0, 'h3C, 1,  1, 'hA5,  1, 1,  1,  1,  1,   1};
    vecs[5]  = '{0, 1, 1, 0, 0, 0,    1,  0, 0,     0, 0,  0,  1,  1,   1};
    vecs[6]  = '{0, 1, 1, 0, 0, 0,    0,  0, 0,     0, 0,  0,  0,  1,   1};
    vecs[7]  = '{0, 1, 1, 1, 0, 'h11, 1,  0, 0,     0, 1,  0,  0,  1,   1};
    vecs[8]  = '{0, 1, 1, 1, 1, 'h22, 1,  0, 0,     0, 2,  1,  0,  1,   1};
    vecs[9]  = '{0, 1, 1, 0, 0, 0,    1,  1, 'h11,  0, 2,  1,  1,  1,   1};
    vecs[10] = '{0, 1, 1, 0, 0, 0,    1,  0, 0,     0, 1,  1,  1,  1,   1};
    vecs[11] = '{0, 1, 1, 0, 0, 0,    1,  1, 'h22,  1, 1,  1,  1,  1,   1};
    vecs[12] = '{0, 1, 1, 0, 0, 0,    1,  0, 0,     0, 0,  0,  1,  1,   1};
    vecs[13] = '{0, 1, 1, 0, 0, 0,    0,  0, 0,     0, 0,  0,  0,  1,   1};
    vecs[14] = '{1, 1, 1, 1, 1, 'h77, 1,  0, 0,     0, 0,  0,  0,  0,   0};
    vecs[15] = '{0, 1, 1, 0, 0, 0,    0,  0, 0,     0, 0,  0,  0,  1,   1};

    // Asynchronous reset values.
    #1 rst_n = 1'b0;
    #2;
    check("reset s_tready", int'(s_tready_o), 0);
    check("reset m_tvalid", int'(m_tvalid_o), 0);
    check("reset m_tdata", int'(m_tdata_o), 0);
    check("reset level", int'(level_o), 0);
    check("reset pkt_cnt", int'(pkt_cnt_o), 0);
    check("reset blk_out", int'(blk_out_ready_o), 0);
    #9 rst_n = 1'b1;
    tick();
    check("s_tready first clock after reset", int'(s_tready_o), 1);
    configured_i = 1'b1;
    cycle_i      = 1'b1;
    tick();
    tick();

    // Per-cycle vector table.
    for (int i = 0; i < NV; i++) begin
      flush_i      = vecs[i].flush[0];
      configured_i = vecs[i].cfg[0];
      cycle_i      = vecs[i].cyc[0];
      s_tvalid_i   = vecs[i].sv[0];
      s_tlast_i    = vecs[i].sl[0];
      s_tdata_i    = vecs[i].sd[7:0];
      m_tready_i   = vecs[i].mr[0];
      tick();
      check($sformatf("v%0d m_tvalid", i), int'(m_tvalid_o), vecs[i].mv);
      if (vecs[i].mv != 0) begin
        check($sformatf("v%0d m_tdata", i), int'(m_tdata_o), vecs[i].md);
        check($sformatf("v%0d m_tlast", i), int'(m_tlast_o), vecs[i].ml);
      end
      check($sformatf("v%0d level", i), int'(level_o), vecs[i].lvl);
      check($sformatf("v%0d pkt_cnt", i), int'(pkt_cnt_o), vecs[i].pkt);
      check($sformatf("v%0d blk_in", i), int'(blk_in_ready_o), vecs[i].bin);
      check($sformatf("v%0d blk_out", i), int'(blk_out_ready_o), vecs[i].bout);
      check($sformatf("v%0d s_tready", i), int'(s_tready_o), vecs[i].str);
      check($sformatf("v%0d overflow", i), int'(overflow_o), 0);
    end
    flush_i = 1'b0; s_tvalid_i = 1'b0; s_tlast_i = 1'b0; m_tready_i = 1'b0; cycle_i = 1'b1;
    tick();

    // Level threshold without packet mode.
    for (int k = 0; k < 4; k++) begin
      write_byte(8'(k), 1'b0);
      check($sformatf("pm0 blk_in after byte %0d", k + 1), int'(p0_blk_in), 0);
    end
    tick();
    check("pm0 blk_in at level 4", int'(p0_blk_in), 0);
    check("pm1 blk_in at level 4 no tlast", int'(blk_in_ready_o), 0);
    write_byte(8'h04, 1'b0);
    check("pm0 blk_in same edge as 5th byte", int'(p0_blk_in), 0);
    tick();
    check("pm0 blk_in after 5th byte", int'(p0_blk_in), 1);
    check("pm0 level", int'(p0_level), 5);
    do_flush();

    // configured_i gates both flags.
    configured_i = 1'b0;
    for (int k = 0; k < 100; k++) write_byte(8'(k), 1'b0);
    tick();
    tick();
    check("unconfigured level", int'(level_o), 100);
    check("unconfigured blk_in", int'(blk_in_ready_o), 0);
    check("unconfigured blk_out", int'(blk_out_ready_o), 0);
    configured_i = 1'b1;
    tick();
    check("configured blk_in", int'(blk_in_ready_o), 1);
    check("configured blk_out", int'(blk_out_ready_o), 1);
    do_flush();

    // Fill to full, then overflow.
    n = 0;
    guard = 0;
    while (n < DEPTH && guard < 3 * DEPTH) begin
      s_tvalid_i = s_tready_o;
      s_tdata_i  = 8'(n);
      tick();
      guard++;
      if (s_tvalid_i) begin
        n++;
        if (n == 1537) check("blk_out at level 1536", int'(blk_out_ready_o), 1);
        if (n == 1538) check("blk_out at level 1537", int'(blk_out_ready_o), 0);
      end
    end
    s_tvalid_i = 1'b0;
    check("fill byte count", n, DEPTH);
    tick();
    check("full s_tready", int'(s_tready_o), 0);
    check("full level", int'(level_o), DEPTH);
    check("full blk_out", int'(blk_out_ready_o), 0);
    check("full overflow before extra write", int'(overflow_o), 0);
    s_tvalid_i = 1'b1;
    tick();
    s_tvalid_i = 1'b0;
    check("overflow set", int'(overflow_o), 1);
    check("level after rejected write", int'(level_o), DEPTH);
    tick();
    check("overflow sticky", int'(overflow_o), 1);
    do_flush();
    check("overflow cleared by flush", int'(overflow_o), 0);
    check("level cleared by flush", int'(level_o), 0);

    // Streaming with random back-pressure across pointer wrap.
    sent = 0; got = 0; errs = 0; both = 0; lvl_m = 0; pkt_m = 0; guard = 0;
    while (got < 3000 && guard < 30000) begin
      s_tvalid_i = (sent < 3000) && s_tready_o;
      s_tdata_i  = 8'(sent * 7 + 3);
      s_tlast_i  = (sent % 64) == 63;
      m_tready_i = 1'($urandom_range(0, 1));
      wf = s_tvalid_i;
      rf = m_tvalid_o && m_tready_i;
      rl = m_tlast_o;
      if (rf) begin
        if (sb.size() == 0) begin
          errs++;
        end else begin
          exp_w = sb.pop_front();
          if ({m_tlast_o, m_tdata_o} != exp_w) errs++;
        end
        got++;
      end
      tick();
      guard++;
      if (wf) begin
        sb.push_back({s_tlast_i, s_tdata_i});
        sent++;
      end
      if (wf && rf) both++;
      lvl_m += int'(wf) - int'(rf);
      pkt_m += int'(wf && s_tlast_i) - int'(rf && rl);
      if (int'(level_o) != lvl_m) errs++;
      if (int'(pkt_cnt_o) != pkt_m) errs++;
    end
    s_tvalid_i = 1'b0; s_tlast_i = 1'b0; m_tready_i = 1'b0;
    check("stream words read", got, 3000);
    check("stream data/level/pkt errors", errs, 0);
    check("stream saw simultaneous write and read", int'(both > 0), 1);
    check("stream overflow", int'(overflow_o), 0);
    tick();
    check("stream final level", int'(level_o), 0);
    check("stream final pkt_cnt", int'(pkt_cnt_o), 0);

    // cycle_i low freezes everything; flush mid-packet.
    do_flush();
    write_byte(8'h40, 1'b0);
    write_byte(8'h41, 1'b0);
    write_byte(8'h42, 1'b0);
    write_byte(8'h43, 1'b1);
    tick();
    tick();
    tick();
    check("pre-hold m_tvalid", int'(m_tvalid_o), 1);
    cycle_i = 1'b0; s_tvalid_i = 1'b1; m_tready_i = 1'b1; s_tdata_i = 8'h99;
    for (int k = 0; k < 10; k++) tick();
    check("cycle low level", int'(level_o), 4);
    check("cycle low pkt_cnt", int'(pkt_cnt_o), 1);
    check("cycle low m_tdata held", int'(m_tdata_o), 'h40);
    check("cycle low overflow", int'(overflow_o), 0);
    cycle_i = 1'b1; s_tvalid_i = 1'b0; m_tready_i = 1'b0;
    write_byte(8'h50, 1'b0);
    write_byte(8'h51, 1'b0);
    check("partial packet level", int'(level_o), 6);
    flush_i = 1'b1; s_tvalid_i = 1'b1; m_tready_i = 1'b1;
    tick();
    flush_i = 1'b0; s_tvalid_i = 1'b0; m_tready_i = 1'b0;
    check("flush level", int'(level_o), 0);
    check("flush pkt_cnt", int'(pkt_cnt_o), 0);
    check("flush m_tvalid", int'(m_tvalid_o), 0);
    tick();
    check("s_tready after flush", int'(s_tready_o), 1);

    // Asynchronous reset mid-packet.
    write_byte(8'h60, 1'b0);
    write_byte(8'h61, 1'b0);
    tick();
    tick();
    check("pre-reset m_tvalid", int'(m_tvalid_o), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset m_tvalid", int'(m_tvalid_o), 0);
    check("async reset m_tdata", int'(m_tdata_o), 0);
    check("async reset level", int'(level_o), 0);
    check("async reset s_tready", int'(s_tready_o), 0);
    check("async reset blk_out", int'(blk_out_ready_o), 0);
    #3 rst_n = 1'b1;
    tick();
    check("post-reset s_tready", int'(s_tready_o), 1);
    tick();
    tick();
    check("post-reset m_tvalid", int'(m_tvalid_o), 0);
    check("post-reset level", int'(level_o), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
